// File: rtl/axi_pkg.sv
// axi_pkg: shared AXI read-channel types and widths for axi_fifo_r and axi_fifo_mem
package axi_pkg;
    localparam int AXI_DATA_WIDTH = 64;
    localparam int AXI_TID_WIDTH  = 8;
    typedef enum logic [1:0] {
        OKAY   = 2'd0,
        EXOKAY = 2'd1,
        SLVERR = 2'd2,
        DECERR = 2'd3
    } axi_resp_e;
    typedef struct packed {
        logic [AXI_DATA_WIDTH-1:0] data;
        logic [AXI_TID_WIDTH-1:0]  id;
        axi_resp_e                 resp;
        logic                      last;
    } r_beat_t;
endpackage

// File: rtl/axi_fifo_mem.sv
// axi_fifo_mem: 2^LOG_DEPTH x r_beat_t storage, one sync write port and one async read port
// Ports: clk; we_i/waddr_i/wdata_i write at tail; raddr_i/rdata_o combinational head read.
module axi_fifo_mem
    import axi_pkg::*;
#(
    parameter int LOG_DEPTH = 8
) (
    input  logic                 clk,
    input  logic                 we_i,
    input  logic [LOG_DEPTH-1:0] waddr_i,
    input  r_beat_t              wdata_i,
    input  logic [LOG_DEPTH-1:0] raddr_i,
    output r_beat_t              rdata_o
);
    r_beat_t mem_q [2**LOG_DEPTH];
    always_ff @(posedge clk) begin
        if (we_i) mem_q[waddr_i] <= wdata_i;
    end
    assign rdata_o = mem_q[raddr_i];
endmodule

// File: rtl/axi_fifo_r.sv
// axi_fifo_r: AXI4 R-channel FIFO replaying memory-side beats in order to the requester side
// Ports: clk, rst_n (sync, active-low); s_r_* beats in from memory; m_r_* head beat out;
//        burst_done pulses the cycle after a last beat pops; bursts_in_q counts stored complete bursts.
// Optional AXI_R_PKT_MODE_EN: hold m_r_valid until a whole burst is stored (or the queue is full).
// Data/id widths are carried in axi_pkg::r_beat_t; keep DATA_WIDTH/TID_WIDTH at the package values.
module axi_fifo_r
    import axi_pkg::*;
#(
    parameter int LOG_QUEUE_SIZE = 8,
    parameter int DATA_WIDTH     = AXI_DATA_WIDTH,
    parameter int TID_WIDTH      = AXI_TID_WIDTH
) (
    input  logic                    clk,
    input  logic                    rst_n,
    input  logic                    s_r_valid,
    output logic                    s_r_ready,
    input  logic [DATA_WIDTH-1:0]   s_r_data,
    input  logic [TID_WIDTH-1:0]    s_r_id,
    input  logic [1:0]              s_r_resp,
    input  logic                    s_r_last,
    output logic                    m_r_valid,
    input  logic                    m_r_ready,
    output logic [DATA_WIDTH-1:0]   m_r_data,
    output logic [TID_WIDTH-1:0]    m_r_id,
    output logic [1:0]              m_r_resp,
    output logic                    m_r_last,
    output logic                    burst_done,
    output logic [LOG_QUEUE_SIZE:0] bursts_in_q
);
    localparam logic [LOG_QUEUE_SIZE:0] DEPTH = (LOG_QUEUE_SIZE+1)'(2**LOG_QUEUE_SIZE);
    localparam logic [LOG_QUEUE_SIZE:0] ONE   = (LOG_QUEUE_SIZE+1)'(1);
    logic [LOG_QUEUE_SIZE-1:0] head_q, head_d, tail_q, tail_d;
    logic [LOG_QUEUE_SIZE:0]   count_q, count_d, bursts_q, bursts_d;
    logic                      s_ready_q, s_ready_d, m_valid_q, m_valid_d, done_q, done_d;
    logic                      push, pop, push_last, pop_last, full_d, empty_d;
    r_beat_t                   wbeat, rbeat;
`ifdef AXI_R_PKT_MODE_EN
    logic                      drain_q, drain_d;
`endif
    always_comb begin
        wbeat     = '{data: s_r_data, id: s_r_id, resp: axi_resp_e'(s_r_resp), last: s_r_last};
        push      = s_r_valid & s_ready_q;
        pop       = m_valid_q & m_r_ready;
        push_last = push & s_r_last;
        pop_last  = pop & rbeat.last;
        head_d    = pop ? head_q + LOG_QUEUE_SIZE'(1) : head_q;
        tail_d    = push ? tail_q + LOG_QUEUE_SIZE'(1) : tail_q;
        count_d   = (push & !pop) ? count_q + ONE : (pop & !push) ? count_q - ONE : count_q;
        bursts_d  = (push_last & !pop_last) ? bursts_q + ONE :
                    (pop_last & !push_last) ? bursts_q - ONE : bursts_q;
        full_d    = count_d == DEPTH;
        empty_d   = count_d == '0;
        s_ready_d = !full_d;
        done_d    = pop_last;
`ifdef AXI_R_PKT_MODE_EN
        // A burst whose first beat has popped keeps draining even if it is no longer complete
        // in the queue (it was released because the queue filled up).
        drain_d   = !empty_d & (pop ? !rbeat.last : drain_q);
        m_valid_d = !empty_d & ((bursts_d != '0) | full_d | drain_d);
`else
        m_valid_d = !empty_d;
`endif
    end
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            head_q    <= '0;
            tail_q    <= '0;
            count_q   <= '0;
            bursts_q  <= '0;
            s_ready_q <= 1'b0;
            m_valid_q <= 1'b0;
            done_q    <= 1'b0;
`ifdef AXI_R_PKT_MODE_EN
            drain_q   <= 1'b0;
`endif
        end else begin
            head_q    <= head_d;
            tail_q    <= tail_d;
            count_q   <= count_d;
            bursts_q  <= bursts_d;
            s_ready_q <= s_ready_d;
            m_valid_q <= m_valid_d;
            done_q    <= done_d;
`ifdef AXI_R_PKT_MODE_EN
            drain_q   <= drain_d;
`endif
        end
    end
    axi_fifo_mem #(.LOG_DEPTH(LOG_QUEUE_SIZE)) u_mem (
        .clk     (clk),
        .we_i    (push & rst_n),
        .waddr_i (tail_q),
        .wdata_i (wbeat),
        .raddr_i (head_q),
        .rdata_o (rbeat)
    );
    assign s_r_ready   = s_ready_q;
    assign m_r_valid   = m_valid_q;
    assign m_r_data    = rbeat.data;
    assign m_r_id      = rbeat.id;
    assign m_r_resp    = rbeat.resp;
    assign m_r_last    = rbeat.last;
    assign burst_done  = done_q;
    assign bursts_in_q = bursts_q;
endmodule

// File: tb/tb_axi_fifo_r.sv
// tb_axi_fifo_r: directed self-checking bench for axi_fifo_r (packet-mode test under AXI_R_PKT_MODE_EN)
module tb_axi_fifo_r;
    logic        clk = 1'b0;
    logic        rst_n;
    logic        s_r_valid, s_r_ready, s_r_last;
    logic [63:0] s_r_data;
    logic [7:0]  s_r_id;
    logic [1:0]  s_r_resp;
    logic        m_r_valid, m_r_ready, m_r_last;
    logic [63:0] m_r_data;
    logic [7:0]  m_r_id;
    logic [1:0]  m_r_resp;
    logic        burst_done;
    logic [8:0]  bursts_in_q;
    int          errors = 0;
    int          checks = 0;

    always #5 clk = ~clk;

    axi_fifo_r dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .s_r_valid   (s_r_valid),
        .s_r_ready   (s_r_ready),
        .s_r_data    (s_r_data),
        .s_r_id      (s_r_id),
        .s_r_resp    (s_r_resp),
        .s_r_last    (s_r_last),
        .m_r_valid   (m_r_valid),
        .m_r_ready   (m_r_ready),
        .m_r_data    (m_r_data),
        .m_r_id      (m_r_id),
        .m_r_resp    (m_r_resp),
        .m_r_last    (m_r_last),
        .burst_done  (burst_done),
        .bursts_in_q (bursts_in_q)
    );

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        rst_n = 1'b0; s_r_valid = 1'b0; m_r_ready = 1'b0;
        s_r_data = '0; s_r_id = '0; s_r_resp = 2'd0; s_r_last = 1'b1;
        step(); step();
        rst_n = 1'b1; s_r_valid = 1'b1;
        for (int i = 0; i < 5; i++) begin s_r_data = 64'(i); step(); end
        rst_n = 1'b0; m_r_ready = 1'b1;
        step(); step(); step();
        checks++; if (s_r_ready !== 1'b0) begin errors++; $display("FAIL rst_s_ready got=%b exp=0", s_r_ready); end
        checks++; if (m_r_valid !== 1'b0) begin errors++; $display("FAIL rst_m_valid got=%b exp=0", m_r_valid); end
        checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL rst_burst_done got=%b exp=0", burst_done); end
        checks++; if (bursts_in_q !== 9'd0) begin errors++; $display("FAIL rst_bursts got=%0d exp=0", bursts_in_q); end
        rst_n = 1'b1; m_r_ready = 1'b0; s_r_data = 64'h11;
        step();
        checks++; if (s_r_ready !== 1'b1) begin errors++; $display("FAIL rel_s_ready got=%b exp=1", s_r_ready); end
        checks++; if (m_r_valid !== 1'b0) begin errors++; $display("FAIL rel_m_valid_early got=%b exp=0", m_r_valid); end
        step();
        s_r_valid = 1'b0;
        checks++; if (m_r_valid !== 1'b1) begin errors++; $display("FAIL rel_m_valid got=%b exp=1", m_r_valid); end
        checks++; if (m_r_data !== 64'h11) begin errors++; $display("FAIL rel_data got=%h exp=11", m_r_data); end
        checks++; if (bursts_in_q !== 9'd1) begin errors++; $display("FAIL rel_bursts got=%0d exp=1", bursts_in_q); end
        m_r_ready = 1'b1;
        step();
        m_r_ready = 1'b0;
        checks++; if (burst_done !== 1'b1) begin errors++; $display("FAIL rel_done got=%b exp=1", burst_done); end
        checks++; if (m_r_valid !== 1'b0) begin errors++; $display("FAIL rel_empty got=%b exp=0", m_r_valid); end
        step();
        checks++; if (burst_done !== 1'b0) begin errors++; $display("FAIL rel_done_pulse got=%b exp=0", burst_done); end
    endtask

    task automatic test_fill();
        m_r_ready = 1'b0; s_r_id = 8'h5A; s_r_last = 1'b1; s_r_resp = 2'd0;
        for (int i = 0; i < 256; i++) begin
            s_r_valid = 1'b1; s_r_data = 64'(i);
            checks++; if (s_r_ready !== 1'b1) begin errors++; $display("FAIL fill_ready beat=%0d got=%b exp=1", i, s_r_ready); end
            step();
        end
        s_r_valid = 1'b0;
        checks++; if (s_r_ready !== 1'b0) begin errors++; $display("FAIL full_ready got=%b exp=0", s_r_ready); end
        checks++; if (bursts_in_q !== 9'd256) begin errors++; $display("FAIL full_bursts got=%0d exp=256", bursts_in_q); end
        checks++; if (m_r_data !== 64'd0 || m_r_id !== 8'h5A) begin errors++; $display("FAIL full_head got=%h/%h exp=0/5a", m_r_data, m_r_id); end
        m_r_ready = 1'b1;
        step();
        m_r_ready = 1'b0;
        checks++; if (s_r_ready !== 1'b1) begin errors++; $display("FAIL pop_reready got=%b exp=1", s_r_ready); end
        checks++; if (bursts_in_q !== 9'd255) begin errors++; $display("FAIL pop_bursts got=%0d exp=255", bursts_in_q); end
        checks++; if (m_r_data !== 64'd1) begin errors++; $display("FAIL pop_head got=%0d exp=1", m_r_data); end
        m_r_ready = 1'b1;
        for (int i = 0; i < 255; i++) step();
        m_r_ready = 1'b0;
        checks++; if (m_r_valid !== 1'b0 || bursts_in_q !== 9'd0) begin errors++; $display("FAIL fill_drain got=%b/%0d exp=0/0", m_r_valid, bursts_in_q); end
    endtask

    task automatic test_order_wrap();
        int  sent = 0, recv = 0, cyc = 0;
        bit  pu, po;
        s_r_resp = 2'd0;
        while (recv < 600 && cyc < 6000) begin
            s_r_valid = (sent < 600) && ($urandom_range(0, 3) != 0);
            s_r_data = 64'(sent); s_r_id = 8'(sent); s_r_last = (sent % 3 == 2);
            m_r_ready = ($urandom_range(0, 3) != 0);
            pu = s_r_valid && s_r_ready;
            po = m_r_valid && m_r_ready;
            if (po) begin
                checks++; if (m_r_data !== 64'(recv)) begin errors++; $display("FAIL order idx=%0d got=%0d exp=%0d", recv, m_r_data, recv); end
            end
            step();
            sent += int'(pu); recv += int'(po); cyc++;
        end
        s_r_valid = 1'b0; m_r_ready = 1'b0;
        checks++; if (recv != 600) begin errors++; $display("FAIL order_count got=%0d exp=600", recv); end
        checks++; if (m_r_valid !== 1'b0 || bursts_in_q !== 9'd0) begin errors++; $display("FAIL order_idle got=%b/%0d exp=0/0", m_r_valid, bursts_in_q); end
    endtask

    task automatic test_back_to_back();
        int n = 0;
        m_r_ready = 1'b0; s_r_resp = 2'd0; s_r_id = 8'h0;
        for (int i = 0; i < 128; i++) begin
            s_r_valid = 1'b1; s_r_data = 64'(i); s_r_last = (i % 2 == 1);
            step();
        end
        checks++; if (bursts_in_q !== 9'd64) begin errors++; $display("FAIL b2b_pre_bursts got=%0d exp=64", bursts_in_q); end
        for (int k = 0; k < 50; k++) begin
            s_r_valid = 1'b1; m_r_ready = 1'b1; s_r_data = 64'(128 + k); s_r_last = (k % 2 == 1);
            checks++; if (s_r_ready !== 1'b1 || m_r_valid !== 1'b1 || m_r_data !== 64'(k)) begin
                errors++; $display("FAIL b2b cyc=%0d got=%b/%b/%0d exp=1/1/%0d", k, s_r_ready, m_r_valid, m_r_data, k);
            end
            step();
        end
        s_r_valid = 1'b0; m_r_ready = 1'b0;
        checks++; if (bursts_in_q !== 9'd64) begin errors++; $display("FAIL b2b_bursts got=%0d exp=64", bursts_in_q); end
        m_r_ready = 1'b1;
        while (m_r_valid === 1'b1 && n < 300) begin
            if (m_r_data !== 64'(50 + n)) begin errors++; $display("FAIL b2b_drain idx=%0d got=%0d exp=%0d", n, m_r_data, 50 + n); end
            checks++;
            step(); n++;
        end
        m_r_ready = 1'b0;
        checks++; if (n != 128) begin errors++; $display("FAIL b2b_count got=%0d exp=128", n); end
    endtask

    task automatic test_burst();
        m_r_ready = 1'b0; s_r_id = 8'd3; s_r_resp = 2'd2;
        for (int b = 0; b < 4; b++) begin
            s_r_valid = 1'b1; s_r_data = 64'(8'hB0 + b); s_r_last = (b == 3);
            step();
            checks++; if (bursts_in_q !== ((b == 3) ? 9'd1 : 9'd0)) begin errors++; $display("FAIL burst_cnt push=%0d got=%0d", b + 1, bursts_in_q); end
        end
        s_r_valid = 1'b0; m_r_ready = 1'b1;
        for (int b = 0; b < 4; b++) begin
            checks++; if (m_r_id !== 8'd3 || m_r_resp !== 2'd2 || m_r_last !== (b == 3) || m_r_data !== 64'(8'hB0 + b)) begin
                errors++; $display("FAIL burst_beat %0d got=%h/%0d/%0d/%b", b, m_r_data, m_r_id, m_r_resp, m_r_last);
            end
            step();
            checks++; if (burst_done !== (b == 3)) begin errors++; $display("FAIL burst_done pop=%0d got=%b exp=%b", b + 1, burst_done, b == 3); end
        end
        m_r_ready = 1'b0;
        step();
        checks++; if (burst_done !== 1'b0 || m_r_valid !== 1'b0 || bursts_in_q !== 9'd0) begin
            errors++; $display("FAIL burst_end got=%b/%b/%0d exp=0/0/0", burst_done, m_r_valid, bursts_in_q);
        end
    endtask

`ifdef AXI_R_PKT_MODE_EN
    task automatic test_pkt_mode();
        int  sent = 0, recv = 0, cyc = 0;
        bit  pu, po;
        m_r_ready = 1'b0; s_r_id = 8'd1; s_r_resp = 2'd0;
        for (int b = 0; b < 4; b++) begin
            s_r_valid = 1'b1; s_r_data = 64'(b); s_r_last = (b == 3);
            step();
            checks++; if (m_r_valid !== (b == 3)) begin errors++; $display("FAIL pkt_valid push=%0d got=%b exp=%b", b + 1, m_r_valid, b == 3); end
        end
        s_r_valid = 1'b0; m_r_ready = 1'b1;
        step(); step(); step(); step();
        m_r_ready = 1'b0;
        checks++; if (m_r_valid !== 1'b0) begin errors++; $display("FAIL pkt_drain got=%b exp=0", m_r_valid); end
        while (recv < 300 && cyc < 3000) begin
            s_r_valid = (sent < 300); s_r_data = 64'(sent); s_r_last = (sent == 299);
            m_r_ready = 1'b1;
            pu = s_r_valid && s_r_ready;
            po = m_r_valid && m_r_ready;
            if (po) begin
                checks++; if (m_r_data !== 64'(recv)) begin errors++; $display("FAIL pkt_order idx=%0d got=%0d", recv, m_r_data); end
            end
            step();
            sent += int'(pu); recv += int'(po); cyc++;
        end
        s_r_valid = 1'b0; m_r_ready = 1'b0;
        checks++; if (recv != 300) begin errors++; $display("FAIL pkt_long got=%0d exp=300", recv); end
    endtask
`endif

    initial begin
        test_reset();
        test_fill();
        test_order_wrap();
        test_back_to_back();
        test_burst();
`ifdef AXI_R_PKT_MODE_EN
        test_pkt_mode();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
